r2_sdf_stage_ctrl: RTL
======================

// Module: r2_sdf_stage_ctrl
// PURPOSE
//  Sequencer for one radix-2 DIF single-path-delay-feedback (SDF) FFT stage.
//  - Streams DATA_SAMPLE words through a DELAY-deep feedback delay line.
//  - Time-shares one cadd and one csub (both saturating through sat_16) to form x[n]+x[n+DELAY] and x[n]-x[n+DELAY].
//  - Emits the sums first, then the differences, each tagged for the downstream twiddle multiplier.
// PARAMETERS
//  DELAY  8  half-frame length for this stage; power of two, >=2; frame = 2*DELAY samples
// PORTS
//  clock          in   1                   stage clock
//  reset_n        in   1                   asynchronous, active-low reset
//  in_valid       in   1                   in_data valid this cycle
//  in_ready       out  1                   stage accepts input; low only in DRAIN
//  in_data        in   DATA_SAMPLE         input sample (data_r/data_i, DATA_WIDTH each)
//  flush          in   1                   drain pending differences when the input has stopped
//  out_valid      out  1                   out_data valid (registered)
//  out_data       out  DATA_SAMPLE         butterfly result
//  out_twiddle_en out  1                   1 = difference output (needs twiddle), 0 = sum
//  out_idx        out  $clog2(DELAY)       position within the half-frame; twiddle address
//  busy           out  1                   state != IDLE
// BEHAVIOUR
//  Reset
//  - Async on reset_n=0: state=IDLE, cnt=0, pending=0; all outputs 0 except in_ready=1.
//  - Delay-line contents are don't-care.
//  - Reset asserted mid-frame discards all data; no partial outputs appear after release.
//  Advance and output timing
//  - adv = (in_valid & in_ready) | (state==DRAIN).
//  - Nothing changes on cycles with adv=0; the delay line holds.
//  - Outputs are registered: each result appears 1 cycle after its adv cycle.
//  - out_valid is a 1-cycle pulse per result; there is no output backpressure.
//  Delay line
//  - Circular buffer of DELAY entries, address = cnt[$clog2(DELAY)-1:0].
//  - Read-before-write at the same address in the same adv cycle.
//  States (sdf_state_t)
//  - IDLE: on adv, write in_data to the line -> FILL, cnt=1.
//  - FILL (cnt<DELAY): write in_data to the line.
//      If pending=1, emit the line head with out_twiddle_en=1, out_idx=cnt.
//      At cnt==DELAY-1 with adv -> BFLY.
//  - BFLY (DELAY<=cnt<2*DELAY): on adv, out = cadd(head, in_data) with out_twiddle_en=0,
//      out_idx=cnt-DELAY; the line is written with csub(head, in_data).
//      At cnt==2*DELAY-1 with adv -> FILL, cnt=0, pending=1.
//  - DRAIN: entered from FILL when cnt==0 & pending & !in_valid & flush.
//      Emits the DELAY heads back to back (twiddle_en=1), no writes.
//      After the last head -> IDLE, pending=0.
//  Boundary conditions
//  - flush is ignored unless in FILL at cnt==0 with pending=1 and in_valid=0.
//  - When flush and in_valid coincide, in_valid wins: the next frame starts, flush is ignored.
//  - Back-to-back frames: differences of frame k interleave with the FILL of frame k+1 at full rate, with no bubble.
//  - cnt wraps 2*DELAY-1 -> 0.
//  - Arithmetic is DATA_WIDTH two's complement.
//      cadd/csub form a DATA_WIDTH+1 intermediate, then saturate to [-2^(W-1), 2^(W-1)-1].
//      No scaling by 1/2 inside this block.
// STRUCTURE
//  - sys_defs.vh: DATA_SAMPLE, DATA_WIDTH (existing); add the sdf_state_t enum {IDLE,FILL,BFLY,DRAIN}.
//  - Sub-module sdf_delay_line #(DEPTH): single-pointer circular buffer, read-before-write, enable=adv.
//  - Reuses the existing cadd and csub instances; FSM, counter and output registers stay in this module.
// TESTING
//  1. DELAY=2, input (1,0),(2,0),(3,0),(4,0), then flush=1.
//      -> (4,0),(6,0) with twiddle_en=0, idx 0,1.
//      -> then (-2,0),(-2,0) with twiddle_en=1, idx 0,1; busy drops after the last output.
//  2. Saturation: DELAY=2, x0=(32767,-32768), x2=(1,1).
//      -> sum (32767,-32767).
//      -> diff (32766,-32768).
//      With x0=(-32768,0), x2=(1,0): diff saturates to (-32768,0).
//  3. Stalls: test 1 stimulus with in_valid deasserted for 3 random cycles between samples.
//      -> identical output sequence.
//      -> out_valid never asserted on stall cycles.
//  4. Back-to-back: two frames, 1..4 then 5..8, continuous.
//      -> (4,0),(6,0),(-2,0),(-2,0),(12,0),(14,0).
//      -> then (-2,0),(-2,0) after flush; no gaps.
//  5. Reset mid-BFLY: assert reset_n=0 for 1 cycle after the 3rd sample.
//      -> out_valid=0, busy=0, in_ready=1 immediately.
//      -> a fresh frame then reproduces test 1 exactly.
//  6. Flush/in_valid collision at a frame boundary: flush=1 and in_valid=1 together.
//      -> no DRAIN is entered.
//      -> differences interleave with the new frame as in test 4.

Source files
------------

// File: rtl/r2_sdf_stage_ctrl_pkg.sv
// Shared types and saturating complex arithmetic for the radix-2 SDF FFT stage.
package r2_sdf_stage_ctrl_pkg;

    localparam int unsigned DATA_WIDTH = 16;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data_r;
        logic [DATA_WIDTH-1:0] data_i;
    } data_sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        BFLY  = 2'd2,
        DRAIN = 2'd3
    } sdf_state_t;

    // Clamp a W+1 bit two's-complement value into W bits.
    function automatic logic [DATA_WIDTH-1:0] sat_16(input logic [DATA_WIDTH:0] x);
        if (x[DATA_WIDTH] != x[DATA_WIDTH-1]) begin
            return x[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return x[DATA_WIDTH-1:0];
    endfunction

    function automatic data_sample_t cadd(input data_sample_t a, input data_sample_t b);
        data_sample_t r;
        r.data_r = sat_16({a.data_r[DATA_WIDTH-1], a.data_r} + {b.data_r[DATA_WIDTH-1], b.data_r});
        r.data_i = sat_16({a.data_i[DATA_WIDTH-1], a.data_i} + {b.data_i[DATA_WIDTH-1], b.data_i});
        return r;
    endfunction

    function automatic data_sample_t csub(input data_sample_t a, input data_sample_t b);
        data_sample_t r;
        r.data_r = sat_16({a.data_r[DATA_WIDTH-1], a.data_r} - {b.data_r[DATA_WIDTH-1], b.data_r});
        r.data_i = sat_16({a.data_i[DATA_WIDTH-1], a.data_i} - {b.data_i[DATA_WIDTH-1], b.data_i});
        return r;
    endfunction

endpackage

// File: rtl/r2_sdf_stage_ctrl_delay_line.sv
// Single-pointer circular feedback buffer; the read returns the old entry while it is overwritten.
module r2_sdf_stage_ctrl_delay_line
    import r2_sdf_stage_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  data_sample_t             wr_data,
    output data_sample_t             rd_data
);

    data_sample_t mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clock) begin
        if (en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/r2_sdf_stage_ctrl.sv
// Sequencer for one radix-2 DIF single-path-delay-feedback FFT stage:
// sums stream out during the second half-frame, differences during the next first half.
module r2_sdf_stage_ctrl
    import r2_sdf_stage_ctrl_pkg::*;
#(
    parameter int unsigned DELAY = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  data_sample_t             in_data,
    input  logic                     flush,
    output logic                     out_valid,
    output data_sample_t             out_data,
    output logic                     out_twiddle_en,
    output logic [$clog2(DELAY)-1:0] out_idx,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DELAY);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(DELAY - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(2 * DELAY - 1);

    sdf_state_t   state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          pending, pending_d;

    logic          adv_c;
    logic          wr_en;
    data_sample_t  wr_data, head;
    logic          valid_d, tw_d;
    data_sample_t  data_d;
    logic [AW-1:0] idx_d;

    assign adv_c = (in_valid & in_ready) | (state == DRAIN);

    r2_sdf_stage_ctrl_delay_line #(.DEPTH(DELAY)) u_line (
        .clock   (clock),
        .en      (wr_en),
        .addr    (cnt[AW-1:0]),
        .wr_data (wr_data),
        .rd_data (head)
    );

    // State, counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            pending        <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_twiddle_en <= 1'b0;
            out_idx        <= '0;
            busy           <= 1'b0;
            in_ready       <= 1'b1;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            pending   <= pending_d;
            out_valid <= valid_d;
            if (valid_d) begin
                out_data       <= data_d;
                out_twiddle_en <= tw_d;
                out_idx        <= idx_d;
            end
            busy     <= (state_d != IDLE);
            in_ready <= (state_d != DRAIN);
        end
    end

    // Next state; the DRAIN entry is the one transition taken on a non-advancing cycle.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        pending_d = pending;
        unique case (state)
            IDLE: begin
                if (adv_c) begin
                    state_d   = FILL;
                    cnt_d     = CW'(1);
                    pending_d = 1'b0;
                end
            end
            FILL: begin
                if (adv_c) begin
                    cnt_d = cnt + CW'(1);
                    if (cnt == HALF_LAST) begin
                        state_d   = BFLY;
                        pending_d = 1'b0;
                    end
                end else if ((cnt == '0) && pending && flush) begin
                    state_d = DRAIN;
                end
            end
            BFLY: begin
                if (adv_c) begin
                    if (cnt == FULL_LAST) begin
                        state_d   = FILL;
                        cnt_d     = '0;
                        pending_d = 1'b1;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (cnt == HALF_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Delay-line write and result selection.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = in_data;
        valid_d = 1'b0;
        tw_d    = 1'b0;
        data_d  = '0;
        idx_d   = cnt[AW-1:0];
        unique case (state)
            IDLE: begin
                wr_en = adv_c;
            end
            FILL: begin
                wr_en = adv_c;
                if (adv_c && pending) begin
                    valid_d = 1'b1;
                    tw_d    = 1'b1;
                    data_d  = head;
                end
            end
            BFLY: begin
                if (adv_c) begin
                    wr_en   = 1'b1;
                    wr_data = csub(head, in_data);
                    valid_d = 1'b1;
                    data_d  = cadd(head, in_data);
                end
            end
            DRAIN: begin
                valid_d = 1'b1;
                tw_d    = 1'b1;
                data_d  = head;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

endmodule
